pipelined_logic_unit: RTL and testbench

PIPELINED_LOGIC_UNIT -- requirements
Module: pipelined_logic_unit

---
 rtl/plu_pkg.sv | 18 +
 rtl/plu_pipe_stage.sv | 46 ++++
 rtl/pipelined_logic_unit.sv | 108 ++++++++++
 tb/tb_pipelined_logic_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plu_pkg.sv
// Shared definitions for the pipelined logic unit: operation encoding and default widths.
package plu_pkg;

    localparam int PLU_DEFAULT_WIDTH = 8;
    localparam int PLU_OP_W          = 3;

    typedef enum logic [PLU_OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_XNOR  = 3'b011,
        OP_NAND  = 3'b100,
        OP_NOR   = 3'b101,
        OP_NOT_A = 3'b110,
        OP_PASS_A = 3'b111
    } plu_op_e;

endpackage

// File: rtl/plu_pipe_stage.sv
// One valid/ready register slice; accepts new data whenever it is empty or its
// current contents leave this cycle, so a full pipeline still streams one beat per clock.
module plu_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // Ready looks only at our own occupancy and the downstream ready, never at valid_i.
    assign ready_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipelined_logic_unit.sv
// Two-stage valid/ready bitwise logic unit. Define PLU_RESULT_COUNT_EN to build the
// saturating accepted-result counter; otherwise res_count is tied to zero.
module pipelined_logic_unit
    import plu_pkg::*;
#(
    parameter int WIDTH = PLU_DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             eq,
    output logic             zero,
    output logic [CNT_W-1:0] res_count
);

    localparam int S1_W = PLU_OP_W + 2 * WIDTH;
    localparam int S2_W = WIDTH + 2;

    logic             s1_valid, s1_ready;
    logic [S1_W-1:0]  s1_data;
    logic             s2_ready;
    logic [S2_W-1:0]  s2_data_in, s2_data;

    plu_op_e          s1_op;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [WIDTH-1:0] y_d;

    plu_pipe_stage #(.DW(S1_W)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (in_valid),
        .ready_o (s1_ready),
        .data_i  ({op, a, b}),
        .valid_o (s1_valid),
        .ready_i (s2_ready),
        .data_o  (s1_data)
    );

    assign in_ready = s1_ready;
    assign s1_op    = plu_op_e'(s1_data[S1_W-1 -: PLU_OP_W]);
    assign s1_a     = s1_data[2*WIDTH-1 -: WIDTH];
    assign s1_b     = s1_data[WIDTH-1:0];

    always_comb begin
        y_d = '0;
        case (s1_op)
            OP_AND:    y_d = s1_a & s1_b;
            OP_OR:     y_d = s1_a | s1_b;
            OP_XOR:    y_d = s1_a ^ s1_b;
            OP_XNOR:   y_d = ~(s1_a ^ s1_b);
            OP_NAND:   y_d = ~(s1_a & s1_b);
            OP_NOR:    y_d = ~(s1_a | s1_b);
            OP_NOT_A:  y_d = ~s1_a;
            OP_PASS_A: y_d = s1_a;
            default:   y_d = s1_a;
        endcase
    end

    assign s2_data_in = {y_d, (s1_a == s1_b), (y_d == '0)};

    plu_pipe_stage #(.DW(S2_W)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_i  (s2_data_in),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .data_o  (s2_data)
    );

    assign y    = s2_data[S2_W-1 -: WIDTH];
    assign eq   = s2_data[1];
    assign zero = s2_data[0];

`ifdef PLU_RESULT_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts output handshakes and sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign res_count = cnt_q;
`else
    assign res_count = '0;
`endif

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Self-checking bench for pipelined_logic_unit: directed vector table, stall/reset
// sequences and randomized streaming against a queue-based reference model.
module tb_pipelined_logic_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] y;
    logic             eq;
    logic             zero;
    logic [CNT_W-1:0] res_count;

    pipelined_logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .eq        (eq),
        .zero      (zero),
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             eq;
        logic             zero;
    } res_t;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] ey;
        logic             eeq;
        logic             ezero;
    } vec_t;

    int   passCount = 0;
    int   checkCount = 0;
    int   popCount = 0;
    int   modelCount = 0;
    bit   lastInFire = 1'b0;
    res_t sbQ[$];

    function automatic res_t refResult(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] z);
        res_t r;
        case (o)
            3'd0:    r.y = x & z;
            3'd1:    r.y = x | z;
            3'd2:    r.y = x ^ z;
            3'd3:    r.y = ~(x ^ z);
            3'd4:    r.y = ~(x & z);
            3'd5:    r.y = ~(x | z);
            3'd6:    r.y = ~x;
            default: r.y = x;
        endcase
        r.eq   = (x == z);
        r.zero = (r.y == '0);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Samples both handshakes at the falling edge, i.e. just before they take effect.
    task automatic monitorSample();
        res_t exp;
        lastInFire = 1'b0;
        if (!rst_n) begin
            sbQ.delete();
            modelCount = 0;
        end else begin
            if (out_valid && out_ready) begin
                checkOutput("res_count before pop", res_count, modelCount);
                checkOutput("scoreboard nonempty at pop", sbQ.size() > 0, 1);
                if (sbQ.size() > 0) begin
                    exp = sbQ.pop_front();
                    checkOutput("stream y", y, exp.y);
                    checkOutput("stream eq", eq, exp.eq);
                    checkOutput("stream zero", zero, exp.zero);
                end
                popCount++;
`ifdef PLU_RESULT_COUNT_EN
                if (modelCount < CNT_MAX) modelCount++;
`endif
            end
            if (in_valid && in_ready) begin
                sbQ.push_back(refResult(op, a, b));
                lastInFire = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitorSample();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat;
        op = v.op; a = v.a; b = v.b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("table beat accepted", lastInFire, 1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        checkOutput("table latency", lat + 1, 2);
        checkOutput("table y", y, v.ey);
        checkOutput("table eq", eq, v.eeq);
        checkOutput("table zero", zero, v.ezero);
        tick();
    endtask

    task automatic sendBeat(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
        int n;
        op = o; a = x; b = z;
        in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!lastInFire && n < 20);
        checkOutput("send accepted", lastInFire, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sbQ.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("drain empty", sbQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   acc, pBefore, fires, sent, cyc;
        logic [CNT_W-1:0] expFinal;

        vecs.push_back('{3'b011, 8'hA5, 8'h5A, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{3'b000, 8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0});
        vecs.push_back('{3'b001, 8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b0});
        vecs.push_back('{3'b010, 8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b0});
        vecs.push_back('{3'b011, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b0});
        vecs.push_back('{3'b100, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0});
        vecs.push_back('{3'b101, 8'hF0, 8'hCC, 8'h03, 1'b0, 1'b0});
        vecs.push_back('{3'b110, 8'hF0, 8'hCC, 8'h0F, 1'b0, 1'b0});
        vecs.push_back('{3'b111, 8'hF0, 8'hCC, 8'hF0, 1'b0, 1'b0});
        vecs.push_back('{3'b000, 8'h3C, 8'h3C, 8'h3C, 1'b1, 1'b0});
        vecs.push_back('{3'b010, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b1});

        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset y", y, 0);
        checkOutput("reset eq", eq, 0);
        checkOutput("reset zero", zero, 0);
        checkOutput("reset res_count", res_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] directed vector table");
        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("[TB] backpressure with four offered beats");
        out_ready = 1'b0;
        pBefore = popCount;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            op = 3'd2; a = WIDTH'(i * 17 + 1); b = 8'h0F;
            in_valid = 1'b1;
            tick();
            if (lastInFire) acc++;
        end
        in_valid = 1'b0;
        checkOutput("accepted under stall", acc, 2);
        checkOutput("in_ready under stall", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall out_valid held", out_valid, 1);
            checkOutput("stall y held", y, refResult(3'd2, 8'h01, 8'h0F).y);
            tick();
        end
        out_ready = 1'b1;
        sendBeat(3'd2, 8'd35, 8'h0F);
        sendBeat(3'd2, 8'd52, 8'h0F);
        drain();
        checkOutput("beats out after release", popCount - pBefore, 4);

        $display("[TB] reset with both stages full");
        out_ready = 1'b0;
        sendBeat(3'd1, 8'h12, 8'h34);
        sendBeat(3'd6, 8'h55, 8'h00);
        pBefore = popCount;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", out_valid, 0);
        checkOutput("midreset y", y, 0);
        checkOutput("midreset res_count", res_count, 0);
        checkOutput("midreset in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("no stale beat after reset", popCount - pBefore, 0);
        sendBeat(3'd7, 8'h9C, 8'h01);
        drain();
        checkOutput("single beat after reset", popCount - pBefore, 1);

        $display("[TB] full-rate burst");
        out_ready = 1'b1;
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 7)); a = WIDTH'($urandom); b = WIDTH'($urandom);
            in_valid = 1'b1;
            tick();
            if (lastInFire) fires++;
        end
        in_valid = 1'b0;
        checkOutput("burst throughput", fires, 10);
        drain();

        $display("[TB] random streaming");
        sent = 0;
        cyc = 0;
        while (sent < 100 && cyc < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a = WIDTH'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : WIDTH'($urandom);
            tick();
            if (lastInFire) sent++;
            cyc++;
        end
        checkOutput("random beats sent", sent, 100);
        drain();

`ifdef PLU_RESULT_COUNT_EN
        expFinal = CNT_W'(CNT_MAX);
`else
        expFinal = '0;
`endif
        checkOutput("res_count final", res_count, expFinal);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
